// File: rtl/bcd_pkg.sv
// Shared constants and types for the decimal-to-BCD encoder slice.
package bcd_pkg;

   localparam int DEC_W = 10;
   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t BCD_NONE = 4'd0;

endpackage : bcd_pkg

// File: rtl/dec_prio_enc.sv
// Combinational priority encoder over the ten decimal lines: highest set index,
// any-line-active and more-than-one-line-active.
module dec_prio_enc
   import bcd_pkg::*;
(
   input  logic [DEC_W-1:0] dec,
   output bcd_t             idx,
   output logic             any,
   output logic             multi
);

   logic [BCD_W-1:0] w_count;

   // Ascending scan so the most significant set line overwrites lower ones.
   always_comb begin
      idx     = BCD_NONE;
      w_count = '0;
      for (int i = 0; i < DEC_W; i++) begin
         if (dec[i]) begin
            idx     = bcd_t'(i);
            w_count = w_count + 4'd1;
         end
      end
   end

   assign any   = |dec;
   assign multi = (w_count >= 4'd2);

endmodule : dec_prio_enc

// File: rtl/dec_to_bcd.sv
// Registered decimal-to-BCD encoder: one-cycle latency, valid and multi-hot error flags.
module dec_to_bcd
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DEC_W-1:0] dec,
   output bcd_t             bcd,
   output logic             valid,
   output logic             err
);

   bcd_t w_idx;
   logic w_any;
   logic w_multi;

   bcd_t r_bcd;
   logic r_valid;
   logic r_err;

   dec_prio_enc u_enc (
      .dec   (dec),
      .idx   (w_idx),
      .any   (w_any),
      .multi (w_multi)
   );

   // No accumulated state: every edge replaces all three outputs with the new sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd   <= BCD_NONE;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_bcd   <= w_idx;
         r_valid <= w_any;
         r_err   <= w_multi;
      end
   end

   assign bcd   = r_bcd;
   assign valid = r_valid;
   assign err   = r_err;

endmodule : dec_to_bcd

// File: tb/tb_dec_to_bcd.sv
// Self-checking bench for dec_to_bcd: directed scenarios plus randomized samples
// compared against an arithmetic reference model.
module tb_dec_to_bcd;

   logic       clk;
   logic       rst_n;
   logic [9:0] dec;
   logic [3:0] bcd;
   logic       valid;
   logic       err;

   int assertCount = 0;
   int failCount   = 0;

   dec_to_bcd dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dec   (dec),
      .bcd   (bcd),
      .valid (valid),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: highest set index by repeated halving, flags by bit counting.
   function automatic void refModel(input logic [9:0] d, output logic [3:0] eBcd,
                                    output logic eValid, output logic eErr);
      int v;
      int hi;
      v  = int'(d);
      hi = 0;
      while (v > 1) begin
         v  = v / 2;
         hi = hi + 1;
      end
      eBcd   = (d == 10'd0) ? 4'd0 : 4'(hi);
      eValid = (d != 10'd0);
      eErr   = ($countones(d) >= 2);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkTriple(input string tag, input logic [3:0] eBcd,
                              input logic eValid, input logic eErr);
      checkOutput({tag, ".bcd"},   32'(bcd),   32'(eBcd));
      checkOutput({tag, ".valid"}, 32'(valid), 32'(eValid));
      checkOutput({tag, ".err"},   32'(err),   32'(eErr));
   endtask

   task automatic checkSample(input string tag, input logic [9:0] d);
      logic [3:0] eBcd;
      logic       eValid;
      logic       eErr;
      refModel(d, eBcd, eValid, eErr);
      checkTriple(tag, eBcd, eValid, eErr);
   endtask

   // Drive at the falling edge, check 1 time unit after the following rising edge.
   task automatic applyStimulus(input string tag, input logic [9:0] d);
      @(negedge clk);
      dec = d;
      @(posedge clk);
      #1;
      checkSample(tag, d);
      checkOutput({tag, ".range"}, 32'(bcd <= 4'd9), 32'd1);
   endtask

   initial begin
      logic [9:0] d;
      rst_n = 1'b0;
      dec   = 10'b1000000000;

      // Reset held low: outputs cleared immediately and across edges.
      #1;
      checkTriple("rstImm", 4'd0, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
         checkTriple("rstHold", 4'd0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkTriple("rstRelease", 4'd9, 1'b1, 1'b0);

      // One-hot walk preceded by zero.
      applyStimulus("walkZero", 10'b0);
      for (int i = 0; i < 10; i++) begin
         d = 10'(1) << i;
         applyStimulus($sformatf("walk%0d", i), d);
      end

      // Zero after a non-zero digit.
      applyStimulus("pre7", 10'b0010000000);
      applyStimulus("zeroIn", 10'b0);

      // Multi-hot priority and error clearing.
      applyStimulus("multi52", 10'b0000100100);
      applyStimulus("multiAll", 10'b1111111111);
      applyStimulus("clean3", 10'b0000001000);

      // Glitches between edges do not reach the outputs.
      applyStimulus("pre2", 10'b0000000100);
      @(negedge clk);
      dec = 10'b1111000000;
      #1;
      dec = 10'b0000000011;
      #1;
      dec = 10'b0001000000;
      #1;
      checkTriple("glitchHold", 4'd2, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkTriple("glitchEdge", 4'd6, 1'b1, 1'b0);

      // Asynchronous reset between edges discards the in-flight sample.
      applyStimulus("pre4", 10'b0000010000);
      dec = 10'b1000000000;
      #2;
      rst_n = 1'b0;
      #1;
      checkTriple("midRst", 4'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkTriple("midRstEdge", 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      dec   = 10'b0000000010;
      @(posedge clk);
      #1;
      checkTriple("midRstRelease", 4'd1, 1'b1, 1'b0);

      // Randomized mix of zero, one-hot and arbitrary patterns.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 2))
            0:       d = 10'b0;
            1:       d = 10'(1) << $urandom_range(0, 9);
            default: d = 10'($urandom);
         endcase
         applyStimulus("rand", d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule : tb_dec_to_bcd

// File: doc/dec_to_bcd.md
# dec_to_bcd

Registered 10-line decimal-to-BCD encoder. It converts a one-hot decimal key vector (line *i* = digit *i*) into a 4-bit BCD digit, with a valid flag and a multi-hot error flag. It sits between a decimal keypad/selector front end and BCD consumers such as 7-segment decoders and BCD arithmetic.

## Interface
- Parameters: none. Input width (10) and output width (4) are fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- dec  in  10  decimal lines; bit *i* high selects digit *i* (bit 0 = digit 0 … bit 9 = digit 9)
- bcd  out  4  encoded BCD digit, 0–9, registered
- valid  out  1  high when at least one `dec` line was active in the sampled cycle
- err  out  1  high when two or more `dec` lines were active in the sampled cycle

## Operation
- Each rising `clk` edge samples `dec` and updates `bcd`, `valid` and `err` together.
- Exactly one line high at bit *i*:
  - `bcd` = *i*
  - `valid` = 1
  - `err` = 0
  - Examples: 10'b0000000001 → 0; 10'b0000000010 → 1; 10'b1000000000 → 9.
- No line high (10'b0000000000):
  - `bcd` = 4'd0, `valid` = 0, `err` = 0.
  - Downstream logic must use `valid` to tell "digit 0" apart from "no key".
- Two or more lines high:
  - Priority goes to the highest index, so `bcd` = index of the most significant set bit.
  - `valid` = 1, `err` = 1.
- `bcd` never exceeds 9. Codes 10–15 are never produced.
- Pure function of the current sample. There is no sticky or accumulated state, so `err` clears on the next clean sample.
- X/Z on `dec` is not supported. Behaviour is undefined and verification must not drive it.

## Timing
- Latency: exactly one clock. The `dec` value present at edge *n* is reflected on the outputs after edge *n*. No combinational path from `dec` to the outputs.
- Throughput: one new sample per cycle. No handshake and no stall.
- Reset:
  - `rst_n` low forces `bcd` = 0, `valid` = 0 and `err` = 0 immediately, without waiting for a clock edge.
  - The outputs hold those values while `rst_n` is low.
- Reset release: the first edge with `rst_n` high samples `dec` normally. There are no extra warm-up cycles.
- Reset asserted mid-stream: the in-flight sample is discarded. Output is 0/0/0 until the first post-release edge.
- Input changes between edges have no effect on the outputs.

## Structure
- Shared package `bcd_pkg`:
  - constants `DEC_W = 10`, `BCD_W = 4`, `BCD_NONE = 4'd0`
  - typedef `bcd_t` (logic [3:0])
- One combinational sub-module, `dec_prio_enc`. It takes `dec[9:0]` and produces:
  - `idx[3:0]`: highest set bit
  - `any`: OR-reduction of the input
  - `multi`: set-bit count ≥ 2, computed by popcount or a pairwise-OR chain
- `dec_to_bcd` instantiates `dec_prio_enc` and registers its three outputs in one always block with asynchronous active-low reset.

## Test plan
- Reset: drive `rst_n` = 0 with `dec` = 10'b1000000000 → `bcd` = 0, `valid` = 0, `err` = 0 immediately and for all edges while `rst_n` is low. Release → next edge gives `bcd` = 9, `valid` = 1.
- One-hot walk: apply 10'b0000000000, then bits 0 through 9 one per cycle → `bcd` goes 0, 0, 1, 2, …, 9 one cycle later. `valid` goes 0 then 1 throughout. `err` stays 0.
- Zero input: `dec` = 0 after `bcd` = 7 → next edge gives `bcd` = 0, `valid` = 0, `err` = 0.
- Multi-hot: 10'b0000100100 → `bcd` = 5, `valid` = 1, `err` = 1. Then 10'b1111111111 → `bcd` = 9, `err` = 1. Then 10'b0000001000 → `bcd` = 3, `err` = 0.
- Latency and glitch: toggle `dec` between edges, returning to 10'b0001000000 before the edge → outputs change only at edges and show `bcd` = 6.
- Async reset mid-stream: assert `rst_n` between edges while `bcd` = 4 → outputs go 0/0/0 before the next edge.
